// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: immediate-mode and FSM-state encodings shared by the immediate generator.
package imm_gen_pkg;
    localparam logic [1:0] IMM_LI     = 2'd0;
    localparam logic [1:0] IMM_SHAMT  = 2'd1;
    localparam logic [1:0] IMM_UPPER  = 2'd2;
    localparam logic [1:0] IMM_PREFIX = 2'd3;
    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_PFX_HELD = 1'b1;
endpackage

// File: rtl/imm_gen_fmt.sv
// imm_gen_fmt: combinational mode/format mux producing the immediate and its prefix-used flag.
module imm_gen_fmt
    import imm_gen_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int IMM_W     = 21,
    parameter int SHAMT_W   = 5,
    parameter int SHAMT_LSB = 6
) (
    input  logic [IMM_W-1:0]        code,
    input  logic [1:0]              sel,
    input  logic [DATA_W-IMM_W-1:0] prefix,
    input  logic                    pfx_valid,
    output logic [DATA_W-1:0]       data,
    output logic                    pfx_used
);
    localparam int PFX_W = DATA_W - IMM_W;

    // A held prefix only combines with LI; other modes ignore it.
    always_comb begin
        data = (sel == IMM_LI)    ? (pfx_valid ? {prefix, code} : {{PFX_W{code[IMM_W-1]}}, code})
             : (sel == IMM_SHAMT) ? {{(DATA_W-SHAMT_W){1'b0}}, code[SHAMT_LSB +: SHAMT_W]}
             : (sel == IMM_UPPER) ? {code[PFX_W-1:0], {IMM_W{1'b0}}}
             : '0;
        pfx_used = pfx_valid && (sel == IMM_LI);
    end
endmodule

// File: rtl/imm_gen_seq.sv
// imm_gen_seq: registered immediate generator with two-beat PREFIX mode and valid/ready handshake.
// Optional IMM_GEN_PFX_ERR_EN adds Pfx_Err, pulsing when a held prefix is dropped or overwritten.
module imm_gen_seq
    import imm_gen_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int IMM_W     = 21,
    parameter int SHAMT_W   = 5,
    parameter int SHAMT_LSB = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [IMM_W-1:0]  Instruction_Code,
    input  logic [1:0]        Imm_Sel,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Gen_Imm_Data,
`ifdef IMM_GEN_PFX_ERR_EN
    output logic              Pfx_Err,
`endif
    output logic              Pfx_Used
);
    localparam int PFX_W = DATA_W - IMM_W;

    logic [0:0]        state_q, state_d;
    logic [PFX_W-1:0]  pfx_q, pfx_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              used_q, used_d;
    logic [DATA_W-1:0] fmt_data;
    logic              fmt_used;
    logic              accept, is_pfx;

    imm_gen_fmt #(
        .DATA_W(DATA_W), .IMM_W(IMM_W), .SHAMT_W(SHAMT_W), .SHAMT_LSB(SHAMT_LSB)
    ) u_fmt (
        .code(Instruction_Code),
        .sel(Imm_Sel),
        .prefix(pfx_q),
        .pfx_valid(state_q == ST_PFX_HELD),
        .data(fmt_data),
        .pfx_used(fmt_used)
    );

    assign In_Ready = !reset && (!out_valid_q || Out_Ready);
    assign accept   = In_Valid && In_Ready;
    assign is_pfx   = (Imm_Sel == IMM_PREFIX);

    // PREFIX beats only touch the prefix register; the output slot just drains on pop.
    always_comb begin
        state_d     = accept ? (is_pfx ? ST_PFX_HELD : ST_IDLE) : state_q;
        pfx_d       = (accept && is_pfx) ? Instruction_Code[PFX_W-1:0] : pfx_q;
        out_valid_d = (accept && !is_pfx) ? 1'b1 : (Out_Ready ? 1'b0 : out_valid_q);
        data_d      = (accept && !is_pfx) ? fmt_data : data_q;
        used_d      = (accept && !is_pfx) ? fmt_used : used_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pfx_q       <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            used_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pfx_q       <= pfx_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            used_q      <= used_d;
        end
    end

`ifdef IMM_GEN_PFX_ERR_EN
    logic err_q, err_d;
    always_comb begin
        err_d = accept && (state_q == ST_PFX_HELD) && (Imm_Sel != IMM_LI);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end
    assign Pfx_Err = err_q;
`endif

    assign Out_Valid    = out_valid_q;
    assign Gen_Imm_Data = data_q;
    assign Pfx_Used     = used_q;
endmodule
